// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_resp
// Brief    : Data-memory responder for the pipelined RISC-V core. Word RAM
//            with combinational read / synchronous write, plus a 16-byte
//            status window (CYCLE, TOHOST, SCRATCH, STORE_CNT).
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        err
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES   = 32'(DEPTH) << 2;
  localparam logic [1:0]  SEL_CYCLE   = 2'd0;
  localparam logic [1:0]  SEL_TOHOST  = 2'd1;
  localparam logic [1:0]  SEL_SCRATCH = 2'd2;
  localparam logic [1:0]  SEL_STORE   = 2'd3;

  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   cycle_q,     cycle_d;
  logic          halt_q,      halt_d;
  logic [31:0]   halt_code_q, halt_code_d;
  logic [31:0]   scratch_q,   scratch_d;
  logic [31:0]   store_cnt_q, store_cnt_d;
  logic          err_q,       err_d;

  logic          aligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic          illegal;
  logic          ram_wr;
  logic          mmio_wr;
  logic [AW-1:0] word_idx;
  logic [1:0]    reg_sel;

  // Address decode; RAM takes priority should the window ever overlap it.
  always_comb begin
    aligned  = (addr[1:0] == 2'b00);
    ram_hit  = ce && aligned && (addr < RAM_BYTES);
    mmio_hit = ce && aligned && !ram_hit && (addr[31:4] == MMIO_BASE[31:4]);
    illegal  = ce && !ram_hit && !mmio_hit;
    word_idx = addr[AW+1:2];
    reg_sel  = addr[3:2];
    ram_wr   = ram_hit && we;
    mmio_wr  = mmio_hit && we;
  end

  // Next-state for the status registers and the sticky error flag.
  always_comb begin
    cycle_d     = cycle_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    scratch_d   = scratch_q;
    store_cnt_d = store_cnt_q;
    err_d       = err_q;

    // Free-running until the program signals completion, then frozen.
    if (!halt_q) begin
      cycle_d = cycle_q + 32'd1;
    end

    if (ram_wr && (store_cnt_q != 32'hFFFF_FFFF)) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end

    // CYCLE and STORE_CNT are read-only; writes to them are silently dropped.
    if (mmio_wr) begin
      case (reg_sel)
        SEL_TOHOST: begin
          if (!halt_q) begin
            halt_d      = 1'b1;
            halt_code_d = wdata;
          end
        end
        SEL_SCRATCH: scratch_d = wdata;
        default: ;
      endcase
    end

    if (illegal) begin
      err_d = 1'b1;
    end
  end

  // Status register state; cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q     <= 32'd0;
      halt_q      <= 1'b0;
      halt_code_q <= 32'd0;
      scratch_q   <= 32'd0;
      store_cnt_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      cycle_q     <= cycle_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      scratch_q   <= scratch_d;
      store_cnt_q <= store_cnt_d;
      err_q       <= err_d;
    end
  end

  // RAM store port; contents survive reset, but a store is dropped while reset is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && ram_wr) begin
      mem_q[word_idx] <= wdata;
    end
  end

  // Zero-wait-state load path: the core samples the data in the same cycle.
  always_comb begin
    rdata = 32'd0;
    if (ce && !we) begin
      if (ram_hit) begin
        rdata = mem_q[word_idx];
      end else if (mmio_hit) begin
        case (reg_sel)
          SEL_CYCLE:   rdata = cycle_q;
          SEL_TOHOST:  rdata = halt_code_q;
          SEL_SCRATCH: rdata = scratch_q;
          SEL_STORE:   rdata = store_cnt_q;
          default:     rdata = 32'd0;
        endcase
      end
    end
  end

  assign halt      = halt_q;
  assign halt_code = halt_code_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_resp
// Brief    : Randomised scoreboard bench for data_mem_resp with a behavioural
//            model of the RAM and status window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

  localparam int          DEPTH     = 1024;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        halt;
  logic [31:0] halt_code;
  logic        err;

  data_mem_resp #(
    .DEPTH     (DEPTH),
    .MMIO_BASE (MMIO_BASE),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .halt      (halt),
    .halt_code (halt_code),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] rdata;
    logic        halt;
    logic [31:0] hcode;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_cycle;
  logic        m_halt;
  logic [31:0] m_hcode;
  logic [31:0] m_scratch;
  logic [31:0] m_scnt;
  logic        m_err;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
  endfunction

  function automatic void model_reset();
    m_cycle   = 32'd0;
    m_halt    = 1'b0;
    m_hcode   = 32'd0;
    m_scratch = 32'd0;
    m_scnt    = 32'd0;
    m_err     = 1'b0;
  endfunction

  // One core access occupying one clock period; called and returns at a negedge.
  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic        is_ram, is_mm;
    logic [31:0] off;
    ce = c; we = w; addr = a; wdata = d;
    is_ram = c && (a % 4 == 0) && (a < DEPTH * 4);
    is_mm  = c && !is_ram && (a % 4 == 0) && (a >= MMIO_BASE) && (a <= MMIO_BASE + 12);
    off    = a - MMIO_BASE;
    e.a     = a;
    e.rdata = 32'd0;
    if (c && !w) begin
      if (is_ram) e.rdata = m_mem[a / 4];
      else if (is_mm) begin
        if (off == 0)      e.rdata = m_cycle;
        else if (off == 4) e.rdata = m_hcode;
        else if (off == 8) e.rdata = m_scratch;
        else               e.rdata = m_scnt;
      end
    end
    e.halt  = m_halt;
    e.hcode = m_hcode;
    e.err   = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (!m_halt) m_cycle = m_cycle + 1;
      if (c && !is_ram && !is_mm) m_err = 1'b1;
      if (c && w && is_ram) begin
        m_mem[a / 4] = d;
        if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      end
      if (c && w && is_mm) begin
        if (off == 4 && !m_halt) begin
          m_halt  = 1'b1;
          m_hcode = d;
        end else if (off == 8) begin
          m_scratch = d;
        end
      end
    end
    @(negedge clk);
  endtask

  // Hold reset for the given number of cycles; asserted and released at a negedge.
  task automatic do_reset(input int hold);
    ce = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_hcode", halt_code, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every period with an outstanding expectation is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("rdata@%h", e.a), rdata, e.rdata);
        chk("halt", {31'd0, halt}, {31'd0, e.halt});
        chk("halt_code", halt_code, e.hcode);
        chk("err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic        w;
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    model_reset();
    @(negedge clk);
    do_reset(1);

    // Give every RAM word a known value.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 32'(i * 4), $urandom);

    // Cycle counter after a 3-cycle reset, then wrap.
    do_reset(3);
    repeat (4) drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'hFFFF_FF00, 32'd0);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 32'hFFFF_FF00, 32'd0);
    drive(1'b1, 1'b0, 32'hFFFF_FF00, 32'd0);

    // Store then load next cycle; store counter.
    drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 32'hFFFF_FF0C, 32'd0);

    // SCRATCH round-trip; read-only registers ignore writes without error.
    drive(1'b1, 1'b1, 32'hFFFF_FF08, 32'hA5A5_5A5A);
    drive(1'b1, 1'b0, 32'hFFFF_FF08, 32'd0);
    drive(1'b1, 1'b1, 32'hFFFF_FF00, 32'd0);
    drive(1'b1, 1'b1, 32'hFFFF_FF0C, 32'd0);
    drive(1'b1, 1'b0, 32'hFFFF_FF00, 32'd0);
    drive(1'b1, 1'b0, 32'hFFFF_FF0C, 32'd0);

    // TOHOST: halt, cycle freeze, lock, RAM still usable.
    drive(1'b1, 1'b1, 32'hFFFF_FF04, 32'h1);
    drive(1'b1, 1'b0, 32'hFFFF_FF00, 32'd0);
    drive(1'b1, 1'b0, 32'hFFFF_FF00, 32'd0);
    drive(1'b1, 1'b1, 32'hFFFF_FF04, 32'h2);
    drive(1'b1, 1'b0, 32'hFFFF_FF04, 32'd0);
    drive(1'b1, 1'b1, 32'h20, 32'h0BAD_F00D);
    drive(1'b1, 1'b0, 32'h20, 32'd0);

    // Illegal accesses: misaligned store, out-of-range load.
    drive(1'b1, 1'b1, 32'h12, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'(DEPTH * 4), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'h10, 32'd0);

    // Randomised traffic; word 4 (byte 0x10) is kept intact for the final check.
    do_reset(2);
    for (int n = 0; n < 800; n++) begin
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1:    a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        2:       a = MMIO_BASE + 32'($urandom_range(0, 15));
        3:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
        4:       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        default: a = $urandom;
      endcase
      if (w && a >= 32'h10 && a < 32'h14) a = a + 32'd4;
      drive(($urandom_range(0, 9) < 8), w, a, $urandom);
    end

    // Make sure halt and err are both set, then reset mid-cycle over a pending store.
    drive(1'b1, 1'b1, 32'hFFFF_FF04, 32'h7);
    drive(1'b1, 1'b0, 32'h13, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    ce = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h1234_5678;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_halt", {31'd0, halt}, 32'd0);
    chk("async_err", {31'd0, err}, 32'd0);
    chk("async_hcode", halt_code, 32'd0);
    model_reset();
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 32'hFFFF_FF08, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    @(negedge clk);
    #5;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
